// File: rtl/logic_unit_sched_pkg.sv
// rtl/logic_unit_sched_pkg.sv - operation encodings shared by the logic unit scheduler
package logic_unit_sched_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    localparam op_e OP_DEFAULT = OP_AND;

endpackage

// File: rtl/logic_unit_sched_rr_arbiter.sv
// rtl/logic_unit_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    int             idx;
    logic [IDW-1:0] idx_b;
    logic           found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        idx_b  = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap without a modulo so non-power-of-two N works.
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_b = IDW'(idx);
            if (en && !found && req[idx_b]) begin
                gnt[idx_b] = 1'b1;
                gnt_id     = idx_b;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_unit_sched.sv
// rtl/logic_unit_sched.sv - round-robin scheduler in front of a shared registered logic unit
module logic_unit_sched
    import logic_unit_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_bus,
    input  logic [N*W-1:0] b_bus,
    output logic [N-1:0]   gnt,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_op,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [W-1:0]   out_c,
    input  logic           out_ready
);

    op_e            op_q, op_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_c_q, out_c_d;

    logic           issue_ok;
    logic           arb_en;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   a_sel, b_sel, op_res;

    assign issue_ok = !out_valid_q || out_ready;
    // Reset masks the arbiter so nothing is consumed during a reset edge.
    assign arb_en   = rst_n && issue_ok;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign a_sel = a_bus[int'(gnt_id)*W +: W];
    assign b_sel = b_bus[int'(gnt_id)*W +: W];

    always_comb begin
        op_res = a_sel & b_sel;
        case (op_q)
            OP_AND:  op_res = a_sel & b_sel;
            OP_OR:   op_res = a_sel | b_sel;
            OP_XOR:  op_res = a_sel ^ b_sel;
            OP_NAND: op_res = ~(a_sel & b_sel);
            default: op_res = a_sel & b_sel;
        endcase
    end

    always_comb begin
        op_d        = cfg_we ? op_e'(cfg_op) : op_q;
        ptr_d       = ptr_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        if (|gnt) begin
            out_c_d     = op_res;
            out_id_d    = gnt_id;
            out_valid_d = 1'b1;
            ptr_d       = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end else if (issue_ok) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_DEFAULT;
            ptr_q       <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
        end else begin
            op_q        <= op_d;
            ptr_q       <= ptr_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_c     = out_c_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
// tb/tb_logic_unit_sched.sv - scoreboard bench for logic_unit_sched
module tb_logic_unit_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_bus;
    logic [N*W-1:0] b_bus;
    logic [N-1:0]   gnt;
    logic           cfg_we;
    logic [1:0]     cfg_op;
    logic           out_valid;
    logic [1:0]     out_id;
    logic [W-1:0]   out_c;
    logic           out_ready;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];

    int n_cmp;
    int n_err;

    logic [1:0] ptr_m;
    logic [1:0] op_m;
    logic       vld_m;

    logic [7:0] save_c;
    logic [1:0] save_id;

    logic_unit_sched #(.N(N), .W(W), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .cfg_we    (cfg_we),
        .cfg_op    (cfg_op),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_c     (out_c),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_bus[i*8 +: 8] = a;
        b_bus[i*8 +: 8] = b;
    endtask

    // One clock: check the grant against the model, push the expected result,
    // then after the edge check out_valid and pop/compare any new result.
    task automatic cyc(input logic chk_g, input logic [3:0] want_g);
        logic [3:0] eg;
        int         k;
        logic       got;
        exp_t       e;
        #1;
        if (chk_g) check_eq("gnt_dir", {28'd0, gnt}, {28'd0, want_g});
        eg  = '0;
        k   = 0;
        got = 1'b0;
        if (rst_n && (!vld_m || out_ready)) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (int'(ptr_m) + i) % N;
                if (eg == 4'd0 && req[j]) begin
                    eg[j] = 1'b1;
                    k     = j;
                end
            end
        end
        check_eq("gnt", {28'd0, gnt}, {28'd0, eg});
        if (eg != 4'd0) begin
            e.id = k[1:0];
            e.c  = calc(op_m, a_bus[k*8 +: 8], b_bus[k*8 +: 8]);
            sb.push_back(e);
            ptr_m = 2'((k + 1) % N);
            vld_m = 1'b1;
            got   = 1'b1;
        end else if (!rst_n || !vld_m || out_ready) begin
            vld_m = 1'b0;
        end
        if (!rst_n) begin
            ptr_m = 2'd0;
            op_m  = 2'b00;
            vld_m = 1'b0;
        end else if (cfg_we) begin
            op_m = cfg_op;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, vld_m});
        if (got) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("out_id", {30'd0, out_id}, {30'd0, e.id});
                check_eq("out_c", {24'd0, out_c}, {24'd0, e.c});
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        ptr_m     = 2'd0;
        op_m      = 2'b00;
        vld_m     = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        a_bus     = '0;
        b_bus     = '0;
        cfg_we    = 1'b0;
        cfg_op    = 2'b00;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with all requesters asserted
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        check_eq("rst_out_c", {24'd0, out_c}, 32'd0);
        check_eq("rst_out_id", {30'd0, out_id}, 32'd0);
        rst_n = 1'b1;

        // Round-robin with AND; the first grant after release is requester 0
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < N; r++) set_ops(r, 8'($urandom), 8'($urandom));
            cyc(1'b1, 4'(1 << (i % 4)));
        end

        // Move pointer to 3, then skip/wrap with req=0101
        req = 4'b0100;
        cyc(1'b1, 4'b0100);
        req = 4'b0101;
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0001);

        // Backpressure: result pending, consumer stalled for 3 cycles
        req       = 4'b0010;
        out_ready = 1'b0;
        save_c    = out_c;
        save_id   = out_id;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'b0000);
            check_eq("bp_out_c", {24'd0, out_c}, {24'd0, save_c});
            check_eq("bp_out_id", {30'd0, out_id}, {30'd0, save_id});
        end
        out_ready = 1'b1;
        cyc(1'b1, 4'b0010);

        // Config write at the same edge as a grant: old op (AND) applies
        req    = 4'b0001;
        set_ops(0, 8'hF0, 8'h3C);
        cfg_we = 1'b1;
        cfg_op = 2'b10;
        cyc(1'b1, 4'b0001);
        check_eq("race_and", {24'd0, out_c}, 32'h30);
        cfg_we = 1'b0;
        cyc(1'b1, 4'b0001);
        check_eq("race_xor", {24'd0, out_c}, 32'hCC);

        // NAND then idle: out_valid drops, out_c holds
        req    = 4'b0000;
        cfg_we = 1'b1;
        cfg_op = 2'b11;
        cyc(1'b1, 4'b0000);
        cfg_we = 1'b0;
        req    = 4'b0001;
        set_ops(0, 8'hFF, 8'h0F);
        cyc(1'b1, 4'b0001);
        check_eq("nand", {24'd0, out_c}, 32'hF0);
        req = 4'b0000;
        cyc(1'b1, 4'b0000);
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_out_c", {24'd0, out_c}, 32'hF0);

        // Random traffic with random stalls and occasional op changes
        for (int i = 0; i < 80; i++) begin
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_op    = 2'($urandom);
            for (int r = 0; r < N; r++) set_ops(r, 8'($urandom), 8'($urandom));
            cyc(1'b0, 4'b0000);
        end
        cfg_we = 1'b0;

        // Reset during backpressure discards the pending result
        out_ready = 1'b1;
        req       = 4'b0001;
        cyc(1'b0, 4'b0000);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        cyc(1'b1, 4'b0000);
        check_eq("rst_bp_valid", {31'd0, out_valid}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, 4'b0001);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
